// File: rtl/pragmatic_weight_scheduler_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pragmatic_weight_scheduler_pkg
// Description : Shared sizes, state encoding and magnitude helper for the
//               Pragmatic weight scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package pragmatic_weight_scheduler_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int VEC_LENGTH = 16;
    localparam int OFF_WIDTH  = 2;
    localparam int BASE_WIDTH = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

    typedef logic [DATA_WIDTH-1:0] mag_t;

    // Unsigned magnitude; the most negative weight maps to 2**(DATA_WIDTH-1).
    function automatic mag_t to_magnitude(input logic [DATA_WIDTH-1:0] w);
        mag_t r;
        r = w[DATA_WIDTH-1] ? mag_t'(~w + 1'b1) : w;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pragmatic_weight_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pragmatic_weight_scheduler_if
// Description : Weight-load handshake and per-step MAC control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface pragmatic_weight_scheduler_if
    import pragmatic_weight_scheduler_pkg::*;
();
    logic                                       w_valid;
    logic                                       w_ready;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]      w_in;
    logic                                       out_valid;
    logic                                       out_ready;
    logic [VEC_LENGTH-1:0][OFF_WIDTH-1:0]       shift_1st_sel;
    logic [VEC_LENGTH-1:0]                      shift_1st_en;
    logic [VEC_LENGTH-1:0]                      is_neg;
    logic [BASE_WIDTH-1:0]                      shift_2nd_sel;
    logic                                       shift_2nd_en;
    logic                                       last;

    modport master (
        output w_valid, w_in, out_ready,
        input  w_ready, out_valid, shift_1st_sel, shift_1st_en, is_neg,
               shift_2nd_sel, shift_2nd_en, last
    );

    modport slave (
        input  w_valid, w_in, out_ready,
        output w_ready, out_valid, shift_1st_sel, shift_1st_en, is_neg,
               shift_2nd_sel, shift_2nd_en, last
    );

endinterface
`default_nettype wire

// File: rtl/pragmatic_weight_scheduler_lowest_one_enc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lowest_one_enc
// Description : Index of the lowest set bit of a magnitude, with valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module lowest_one_enc
    import pragmatic_weight_scheduler_pkg::*;
(
    input  mag_t                  i_mag,
    output logic                  o_valid,
    output logic [BASE_WIDTH-1:0] o_idx
);

    always_comb begin
        o_valid = |i_mag;
        o_idx   = '0;
        // Scan downward so the lowest set bit wins.
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (i_mag[i]) begin
                o_idx = BASE_WIDTH'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pragmatic_weight_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pragmatic_weight_scheduler
// Description : Streams the essential bits of a signed weight vector as
//               per-lane offsets plus a shared base shift for the Pragmatic MAC.
// Revision    : 1.0 - initial release
// ============================================================================
module pragmatic_weight_scheduler
    import pragmatic_weight_scheduler_pkg::*;
(
    input  wire logic                   clk,
    input  wire logic                   reset,
    pragmatic_weight_scheduler_if.slave bus
);

    localparam logic [BASE_WIDTH-1:0] c_MAX_OFF = BASE_WIDTH'(2**OFF_WIDTH - 1);

    sched_state_t                               r_state;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]      r_mag;
    logic [VEC_LENGTH-1:0]                      r_sgn;

    logic [VEC_LENGTH-1:0]                      w_lane_valid;
    logic [VEC_LENGTH-1:0][BASE_WIDTH-1:0]      w_idx;
    logic [BASE_WIDTH:0]                        w_min_key;
    logic [BASE_WIDTH-1:0]                      w_base;
    logic                                       w_any;
    logic [VEC_LENGTH-1:0][BASE_WIDTH-1:0]      w_diff;
    logic [VEC_LENGTH-1:0]                      w_en;
    logic [VEC_LENGTH-1:0][OFF_WIDTH-1:0]       w_sel;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]      w_mag_next;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]      w_load_mag;
    logic [VEC_LENGTH-1:0]                      w_load_sgn;
    logic                                       w_running;
    logic                                       w_last;
    logic                                       w_done;

    generate
        for (genvar j = 0; j < VEC_LENGTH; j++) begin : g_lane_enc
            lowest_one_enc u_enc (
                .i_mag   (r_mag[j]),
                .o_valid (w_lane_valid[j]),
                .o_idx   (w_idx[j])
            );
        end
    endgenerate

    // Empty lanes carry key 2**BASE_WIDTH so they never win; an all-empty
    // vector therefore yields base 0.
    always_comb begin
        w_min_key = {1'b1, {BASE_WIDTH{1'b0}}};
        for (int j = 0; j < VEC_LENGTH; j++) begin
            if ({~w_lane_valid[j], w_idx[j]} < w_min_key) begin
                w_min_key = {~w_lane_valid[j], w_idx[j]};
            end
        end
    end

    assign w_base = w_min_key[BASE_WIDTH-1:0];
    assign w_any  = |w_lane_valid;

    always_comb begin
        for (int j = 0; j < VEC_LENGTH; j++) begin
            w_diff[j]     = w_idx[j] - w_base;
            w_en[j]       = w_lane_valid[j] && (w_diff[j] <= c_MAX_OFF);
            w_sel[j]      = w_en[j] ? w_diff[j][OFF_WIDTH-1:0] : '0;
            w_mag_next[j] = w_en[j] ? (r_mag[j] & ~(mag_t'(1) << w_idx[j])) : r_mag[j];
            w_load_mag[j] = to_magnitude(bus.w_in[j]);
            w_load_sgn[j] = bus.w_in[j][DATA_WIDTH-1];
        end
    end

    assign w_running = (r_state == RUN);
    assign w_last    = w_running && (w_mag_next == '0);
    assign w_done    = w_running && bus.out_ready && w_last;

    assign bus.out_valid     = w_running;
    assign bus.w_ready       = !w_running || w_done;
    assign bus.shift_1st_sel = w_sel;
    assign bus.shift_1st_en  = w_en;
    assign bus.is_neg        = r_sgn;
    assign bus.shift_2nd_sel = w_base;
    assign bus.shift_2nd_en  = w_any;
    assign bus.last          = w_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_mag   <= '0;
            r_sgn   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.w_valid) begin
                        r_mag   <= w_load_mag;
                        r_sgn   <= w_load_sgn;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.out_ready) begin
                        if (w_last) begin
                            // A waiting vector is taken on the closing step.
                            if (bus.w_valid) begin
                                r_mag <= w_load_mag;
                                r_sgn <= w_load_sgn;
                            end else begin
                                r_mag   <= '0;
                                r_sgn   <= '0;
                                r_state <= IDLE;
                            end
                        end else begin
                            r_mag <= w_mag_next;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pragmatic_weight_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pragmatic_weight_scheduler
// Description : Directed and randomized checks of the weight scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pragmatic_weight_scheduler;
    import pragmatic_weight_scheduler_pkg::*;

    typedef logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] vec_t;
    typedef struct packed {
        logic [15:0]      en;
        logic [15:0][1:0] sel;
        logic [15:0]      neg;
        logic [2:0]       base;
        logic             base_en;
        logic             last;
    } step_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    step_t obs_q[$];
    step_t exp_q[$];

    always #5 clk = ~clk;

    pragmatic_weight_scheduler_if bus ();

    pragmatic_weight_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic step_t sample();
        step_t s;
        s.en      = bus.shift_1st_en;
        s.sel     = bus.shift_1st_sel;
        s.neg     = bus.is_neg;
        s.base    = bus.shift_2nd_sel;
        s.base_en = bus.shift_2nd_en;
        s.last    = bus.last;
        return s;
    endfunction

    function automatic vec_t fill(input logic [7:0] v);
        vec_t w;
        for (int j = 0; j < VEC_LENGTH; j++) w[j] = v;
        return w;
    endfunction

    // Reference: list each lane's set magnitude bits, then emit steps from
    // the lowest outstanding bits within a 4-position window.
    task automatic model(input vec_t w);
        int    mag[VEC_LENGTH];
        int    lo[VEC_LENGTH];
        int    base;
        bit    fin;
        step_t s;
        exp_q.delete();
        for (int j = 0; j < VEC_LENGTH; j++) begin
            int v;
            v = int'($signed(w[j]));
            mag[j] = (v < 0) ? -v : v;
        end
        fin = 0;
        while (!fin) begin
            s = '0;
            base = 100;
            for (int j = 0; j < VEC_LENGTH; j++) begin
                int b;
                s.neg[j] = w[j][7];
                lo[j] = -1;
                b = 0;
                while (mag[j] != 0 && lo[j] < 0) begin
                    if (((mag[j] >> b) & 1) == 1) lo[j] = b;
                    b++;
                end
                if (lo[j] >= 0 && lo[j] < base) base = lo[j];
            end
            if (base == 100) begin
                s.last = 1'b1;
                exp_q.push_back(s);
                fin = 1;
            end else begin
                s.base    = 3'(base);
                s.base_en = 1'b1;
                for (int j = 0; j < VEC_LENGTH; j++) begin
                    if (lo[j] >= 0 && lo[j] - base <= 3) begin
                        s.en[j]  = 1'b1;
                        s.sel[j] = 2'(lo[j] - base);
                        mag[j]   = mag[j] & ~(1 << lo[j]);
                    end
                end
                fin = 1;
                for (int j = 0; j < VEC_LENGTH; j++) if (mag[j] != 0) fin = 0;
                s.last = fin;
                exp_q.push_back(s);
            end
        end
    endtask

    // Presents a vector and returns at the negedge where its first step is visible.
    task automatic load_vector(input vec_t w, output bit timeout);
        int n;
        n = 0;
        timeout = 0;
        bus.w_valid = 1'b1;
        bus.w_in    = w;
        #1;
        while (!bus.w_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.w_ready) timeout = 1;
        @(negedge clk);
        bus.w_valid = 1'b0;
    endtask

    task automatic capture(input vec_t w, input bit rand_ready, output bit timeout);
        bit done;
        int n;
        done = 0;
        n = 0;
        obs_q.delete();
        load_vector(w, timeout);
        while (!done && n < 64) begin
            bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                obs_q.push_back(sample());
                done = bus.last;
            end
            @(negedge clk);
            n++;
        end
        if (!done) timeout = 1;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        step_t s;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        s = sample();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.w_ready !== 1'b1) begin
            failures++; $display("FAIL reset_w_ready: got %b expected 1", bus.w_ready);
        end
        checks++;
        if (s !== step_t'(0)) begin
            failures++; $display("FAIL reset_outputs: got %h expected 0", s);
        end
        @(negedge clk);
    endtask

    task automatic test_all_neg_one();
        bit to;
        capture(fill(8'hFF), 1'b0, to);
        checks++;
        if (to || obs_q.size() != 1) begin
            failures++; $display("FAIL neg_one_steps: got %0d expected 1 (timeout=%b)", obs_q.size(), to);
        end else begin
            checks++;
            if (obs_q[0].base !== 3'd0 || obs_q[0].en !== 16'hFFFF || obs_q[0].sel !== 32'h0 ||
                obs_q[0].neg !== 16'hFFFF || obs_q[0].base_en !== 1'b1 || obs_q[0].last !== 1'b1) begin
                failures++; $display("FAIL neg_one_step: got %h expected base0 en ffff sel0 neg ffff last1", obs_q[0]);
            end
        end
    endtask

    task automatic test_all_127();
        bit to;
        capture(fill(8'h7F), 1'b0, to);
        checks++;
        if (to || obs_q.size() != 7) begin
            failures++; $display("FAIL p127_steps: got %0d expected 7 (timeout=%b)", obs_q.size(), to);
        end else begin
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (obs_q[k].base !== 3'(k) || obs_q[k].en !== 16'hFFFF || obs_q[k].sel !== 32'h0 ||
                    obs_q[k].neg !== 16'h0 || obs_q[k].last !== (k == 6)) begin
                    failures++; $display("FAIL p127_step%0d: got %h expected base %0d", k, obs_q[k], k);
                end
            end
        end
    endtask

    task automatic test_two_lane();
        bit   to;
        vec_t w;
        w = '0;
        w[0] = 8'h01;
        w[1] = 8'h40;
        capture(w, 1'b0, to);
        checks++;
        if (to || obs_q.size() != 2) begin
            failures++; $display("FAIL two_lane_steps: got %0d expected 2 (timeout=%b)", obs_q.size(), to);
        end else begin
            checks++;
            if (obs_q[0].base !== 3'd0 || obs_q[0].en !== 16'h0001 || obs_q[0].last !== 1'b0) begin
                failures++; $display("FAIL two_lane_step1: got %h expected base0 en 0001 last0", obs_q[0]);
            end
            checks++;
            if (obs_q[1].base !== 3'd6 || obs_q[1].en !== 16'h0002 || obs_q[1].sel !== 32'h0 ||
                obs_q[1].last !== 1'b1) begin
                failures++; $display("FAIL two_lane_step2: got %h expected base6 en 0002 last1", obs_q[1]);
            end
        end
    endtask

    task automatic test_extremes();
        bit to;
        capture(fill(8'h80), 1'b0, to);
        checks++;
        if (to || obs_q.size() != 1 || obs_q[0].base !== 3'd7 || obs_q[0].en !== 16'hFFFF ||
            obs_q[0].sel !== 32'h0 || obs_q[0].neg !== 16'hFFFF || obs_q[0].last !== 1'b1) begin
            failures++; $display("FAIL min_neg: got n=%0d step=%h expected base7 en ffff neg ffff last1",
                                 obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : step_t'(0));
        end
        capture('0, 1'b0, to);
        checks++;
        if (to || obs_q.size() != 1 || obs_q[0] !== step_t'(1)) begin
            failures++; $display("FAIL all_zero: got n=%0d step=%h expected one step with only last",
                                 obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : step_t'(0));
        end
    endtask

    task automatic test_backpressure();
        bit    to;
        step_t snap;
        step_t cur;
        load_vector(fill(8'h7F), to);
        checks++;
        if (to) begin
            failures++; $display("FAIL stall_load: got timeout expected accept");
        end
        for (int step = 0; step < 7; step++) begin
            if (step == 2) begin
                bus.out_ready = 1'b0;
                #1;
                snap = sample();
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    #1;
                    cur = sample();
                    checks++;
                    if (cur !== snap || bus.out_valid !== 1'b1) begin
                        failures++; $display("FAIL stall_hold%0d: got %h expected %h", c, cur, snap);
                    end
                end
            end
            bus.out_ready = 1'b1;
            #1;
            cur = sample();
            checks++;
            if (bus.out_valid !== 1'b1 || cur.base !== 3'(step) || cur.en !== 16'hFFFF ||
                cur.last !== (step == 6)) begin
                failures++; $display("FAIL stall_seq%0d: got %h expected base %0d", step, cur, step);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL stall_idle: got out_valid %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        load_vector(fill(8'h55), to);
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (to || bus.out_valid !== 1'b1 || bus.shift_2nd_sel !== 3'd2 || bus.last !== 1'b0) begin
            failures++; $display("FAIL rst_mid_step2: got base %0d valid %b expected base 2 valid 1",
                                 bus.shift_2nd_sel, bus.out_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.w_ready !== 1'b1 || bus.last !== 1'b0) begin
            failures++; $display("FAIL rst_mid_idle: got valid %b ready %b last %b expected 0 1 0",
                                 bus.out_valid, bus.w_ready, bus.last);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        step_t s;
        bus.out_ready = 1'b1;
        bus.w_valid   = 1'b1;
        bus.w_in      = fill(8'h03);
        @(negedge clk);
        bus.w_in = fill(8'h40);
        #1;
        s = sample();
        checks++;
        if (bus.out_valid !== 1'b1 || s.base !== 3'd0 || s.last !== 1'b0 || bus.w_ready !== 1'b0) begin
            failures++; $display("FAIL b2b_a1: got valid %b base %0d last %b ready %b expected 1 0 0 0",
                                 bus.out_valid, s.base, s.last, bus.w_ready);
        end
        @(negedge clk);
        #1;
        s = sample();
        checks++;
        if (bus.out_valid !== 1'b1 || s.base !== 3'd1 || s.last !== 1'b1 || bus.w_ready !== 1'b1) begin
            failures++; $display("FAIL b2b_a2: got valid %b base %0d last %b ready %b expected 1 1 1 1",
                                 bus.out_valid, s.base, s.last, bus.w_ready);
        end
        @(negedge clk);
        bus.w_valid = 1'b0;
        #1;
        s = sample();
        checks++;
        if (bus.out_valid !== 1'b1 || s.base !== 3'd6 || s.en !== 16'hFFFF || s.last !== 1'b1) begin
            failures++; $display("FAIL b2b_b1: got valid %b step %h expected base 6 en ffff last 1",
                                 bus.out_valid, s);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_idle: got out_valid %b expected 0", bus.out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        vec_t w;
        int   act[VEC_LENGTH];
        int   dot_exp;
        int   dot_got;
        bit   to;
        for (int it = 0; it < 40; it++) begin
            dot_exp = 0;
            for (int j = 0; j < VEC_LENGTH; j++) begin
                case ($urandom_range(0, 5))
                    0:       w[j] = 8'h00;
                    1:       w[j] = 8'h80;
                    default: w[j] = 8'($urandom);
                endcase
                act[j]  = $urandom_range(0, 255) - 128;
                dot_exp += int'($signed(w[j])) * act[j];
            end
            model(w);
            capture(w, 1'b1, to);
            checks++;
            if (to || obs_q.size() != exp_q.size()) begin
                failures++; $display("FAIL rand%0d_steps: got %0d expected %0d (timeout=%b)",
                                     it, obs_q.size(), exp_q.size(), to);
            end else begin
                dot_got = 0;
                for (int k = 0; k < obs_q.size(); k++) begin
                    checks++;
                    if (obs_q[k] !== exp_q[k]) begin
                        failures++; $display("FAIL rand%0d_step%0d: got %h expected %h",
                                             it, k, obs_q[k], exp_q[k]);
                    end
                    for (int j = 0; j < VEC_LENGTH; j++) begin
                        if (obs_q[k].en[j]) begin
                            int t;
                            t = act[j] * (1 << (int'(obs_q[k].sel[j]) + int'(obs_q[k].base)));
                            dot_got += obs_q[k].neg[j] ? -t : t;
                        end
                    end
                end
                checks++;
                if (dot_got != dot_exp) begin
                    failures++; $display("FAIL rand%0d_dot: got %0d expected %0d", it, dot_got, dot_exp);
                end
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.w_valid   = 1'b0;
        bus.w_in      = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_all_neg_one();
        test_all_127();
        test_two_lane();
        test_extremes();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
